// File: rtl/trg_timer_pkg.sv
// Shared definitions for the trigger-latency timer: FSM state encoding
// and the saturation limit of a channel counter.
package trg_timer_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN
  } ch_state_e;

  // All-ones value of a w-bit counter, valid for 1 <= w <= 32.
  function automatic logic [31:0] CNT_MAX(input int w);
    return 32'((33'd1 << w) - 33'd1);
  endfunction

endpackage

// File: rtl/trg_timer_mc_if.sv
// Strobe and result bus of the multi-channel trigger-latency timer.
interface trg_timer_mc_if #(
  parameter int Width = 8,
  parameter int NCH   = 4
);

  logic                   HOLDOFF;
  logic                   CLR;
  logic [NCH-1:0]         START;
  logic [NCH-1:0]         STOP;
  logic [NCH*Width-1:0]   TIME;
  logic [NCH*Width-1:0]   TMAX;
  logic [NCH-1:0]         VALID;
  logic [NCH-1:0]         OVF;

  modport master (
    output HOLDOFF, CLR, START, STOP,
    input  TIME, TMAX, VALID, OVF
  );

  modport slave (
    input  HOLDOFF, CLR, START, STOP,
    output TIME, TMAX, VALID, OVF
  );

endinterface

// File: rtl/trg_timer_ch.sv
// One timer channel: IDLE/RUN FSM, saturating cycle counter and the
// TIME/TMAX/VALID/OVF result registers, optionally with triplicated state.
module trg_timer_ch
  import trg_timer_pkg::*;
#(
  parameter int Width  = 8,
  parameter bit RETRIG = 1'b0,
  parameter bit TMR    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             holdoff,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  output logic [Width-1:0] time_o,
  output logic [Width-1:0] tmax_o,
  output logic             valid_o,
  output logic             ovf_o
);

  localparam logic [Width-1:0] CMAX = Width'(CNT_MAX(Width));
  localparam logic [Width-1:0] ZERO = {Width{1'b0}};
  localparam logic [Width-1:0] ONE  = {{(Width-1){1'b0}}, 1'b1};

  function automatic logic [Width-1:0] vote(input logic [Width-1:0] a,
                                            input logic [Width-1:0] b,
                                            input logic [Width-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  ch_state_e        state_v, state_d;
  logic [Width-1:0] cnt_v, cnt_d, cnt_inc;
  logic [Width-1:0] time_q, time_d, tmax_q, tmax_d;
  logic             valid_q, valid_d, ovf_q, ovf_d;

  if (TMR) begin : g_tmr
    ch_state_e        state_q [3];
    logic [Width-1:0] cnt_q   [3];

    // Three identical copies; a single upset is outvoted on the next read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < 3; i++) begin
          state_q[i] <= S_IDLE;
          cnt_q[i]   <= ZERO;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          state_q[i] <= state_d;
          cnt_q[i]   <= cnt_d;
        end
      end
    end

    assign state_v = ch_state_e'((state_q[0] & state_q[1]) |
                                 (state_q[0] & state_q[2]) |
                                 (state_q[1] & state_q[2]));
    assign cnt_v   = vote(cnt_q[0], cnt_q[1], cnt_q[2]);
  end else begin : g_single
    ch_state_e        state_q;
    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= ZERO;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign state_v = state_q;
    assign cnt_v   = cnt_q;
  end

  assign cnt_inc = (cnt_v == CMAX) ? CMAX : cnt_v + ONE;

  always_comb begin
    state_d = state_v;
    cnt_d   = cnt_v;
    time_d  = time_q;
    tmax_d  = tmax_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (holdoff) begin
      state_d = S_IDLE;
      cnt_d   = ZERO;
    end else if (clr) begin
      // Results are wiped but a running measurement keeps counting.
      time_d = ZERO;
      tmax_d = ZERO;
      ovf_d  = 1'b0;
      if (state_v == S_RUN) begin
        cnt_d = cnt_inc;
      end else begin
        cnt_d = cnt_v;
      end
    end else begin
      case (state_v)
        S_IDLE: begin
          if (start && stop) begin
            time_d  = ZERO;
            valid_d = 1'b1;
          end else if (start) begin
            cnt_d   = ONE;
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_v;
          end
        end
        S_RUN: begin
          if (stop) begin
            time_d  = cnt_v;
            valid_d = 1'b1;
            state_d = S_IDLE;
            if (cnt_v > tmax_q) begin
              tmax_d = cnt_v;
            end else begin
              tmax_d = tmax_q;
            end
          end else if (start && RETRIG) begin
            cnt_d = ONE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CMAX) begin
              ovf_d = 1'b1;
            end else begin
              ovf_d = ovf_q;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q  <= ZERO;
      tmax_q  <= ZERO;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      time_q  <= time_d;
      tmax_q  <= tmax_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign time_o  = time_q;
  assign tmax_o  = tmax_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/trg_timer_mc.sv
// Multi-channel trigger-latency timer: NCH independent channels packed
// onto the result buses, channel k at bits [k*Width +: Width].
module trg_timer_mc #(
  parameter int Width  = 8,
  parameter int NCH    = 4,
  parameter bit RETRIG = 1'b0,
  parameter bit TMR    = 1'b0
) (
  input logic           CLK,
  input logic           RST,
  trg_timer_mc_if.slave bus
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    trg_timer_ch #(
      .Width  (Width),
      .RETRIG (RETRIG),
      .TMR    (TMR)
    ) u_ch (
      .clk     (CLK),
      .rst     (RST),
      .holdoff (bus.HOLDOFF),
      .clr     (bus.CLR),
      .start   (bus.START[k]),
      .stop    (bus.STOP[k]),
      .time_o  (bus.TIME[k*Width +: Width]),
      .tmax_o  (bus.TMAX[k*Width +: Width]),
      .valid_o (bus.VALID[k]),
      .ovf_o   (bus.OVF[k])
    );
  end

endmodule

// File: tb/tb_trg_timer_mc.sv
// Bench for trg_timer_mc: u0 (RETRIG=0, TMR=0) and u1 (RETRIG=1, TMR=1)
// see the same strobes; expected bus values come from a hand-built table.
module tb_trg_timer_mc;

  localparam int W = 8;
  localparam int N = 4;

  typedef struct {
    logic        hold;
    logic        clr;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [31:0] e_t;
    logic [31:0] e_m;
    logic [31:0] e_t1;
    logic [31:0] e_m1;
    logic [3:0]  e_v;
    logic [3:0]  e_o;
  } vec_t;

  logic clk;
  logic rst;

  trg_timer_mc_if #(.Width(W), .NCH(N)) bus0 ();
  trg_timer_mc_if #(.Width(W), .NCH(N)) bus1 ();

  trg_timer_mc #(.Width(W), .NCH(N), .RETRIG(1'b0), .TMR(1'b0)) u0 (
    .CLK (clk), .RST (rst), .bus (bus0)
  );
  trg_timer_mc #(.Width(W), .NCH(N), .RETRIG(1'b1), .TMR(1'b1)) u1 (
    .CLK (clk), .RST (rst), .bus (bus1)
  );

  assign bus1.HOLDOFF = bus0.HOLDOFF;
  assign bus1.CLR     = bus0.CLR;
  assign bus1.START   = bus0.START;
  assign bus1.STOP    = bus0.STOP;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t        vecs[$];
  vec_t        sb[$];
  vec_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cur_t, cur_m, cur_t1, cur_m1;
  logic [3:0]  cur_o;

  function automatic void set2(logic [31:0] t, logic [31:0] m, logic [31:0] t1, logic [31:0] m1);
    cur_t = t; cur_m = m; cur_t1 = t1; cur_m1 = m1;
  endfunction

  function automatic void set(logic [31:0] t, logic [31:0] m);
    set2(t, m, t, m);
  endfunction

  function automatic void add(logic h, logic c, logic [3:0] st, logic [3:0] sp, logic [3:0] v);
    vec_t x;
    x.hold = h; x.clr = c; x.start = st; x.stop = sp;
    x.e_t = cur_t; x.e_m = cur_m; x.e_t1 = cur_t1; x.e_m1 = cur_m1;
    x.e_v = v; x.e_o = cur_o;
    vecs.push_back(x);
  endfunction

  function automatic void idle(int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h want %h", nm, n_vec, got, want);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    bus0.HOLDOFF = v.hold;
    bus0.CLR     = v.clr;
    bus0.START   = v.start;
    bus0.STOP    = v.stop;
    sb.push_back(v);
    @(posedge clk);
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    @(negedge clk);
    bus0.START = 4'h0;
    bus0.STOP  = 4'h0;
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    cmp({tag, " u0.TIME"},  bus0.TIME,        32'h0);
    cmp({tag, " u0.TMAX"},  bus0.TMAX,        32'h0);
    cmp({tag, " u0.VALID"}, {28'h0, bus0.VALID}, 32'h0);
    cmp({tag, " u0.OVF"},   {28'h0, bus0.OVF},   32'h0);
    cmp({tag, " u1.TIME"},  bus1.TIME,        32'h0);
    cmp({tag, " u1.TMAX"},  bus1.TMAX,        32'h0);
    cmp({tag, " u1.VALID"}, {28'h0, bus1.VALID}, 32'h0);
    cmp({tag, " u1.OVF"},   {28'h0, bus1.OVF},   32'h0);
  endtask

  // Scoreboard: each driven vector is checked one step after its edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      cmp("u0.TIME",  bus0.TIME,           mon_e.e_t);
      cmp("u0.TMAX",  bus0.TMAX,           mon_e.e_m);
      cmp("u0.VALID", {28'h0, bus0.VALID}, {28'h0, mon_e.e_v});
      cmp("u0.OVF",   {28'h0, bus0.OVF},   {28'h0, mon_e.e_o});
      cmp("u1.TIME",  bus1.TIME,           mon_e.e_t1);
      cmp("u1.TMAX",  bus1.TMAX,           mon_e.e_m1);
      cmp("u1.VALID", {28'h0, bus1.VALID}, {28'h0, mon_e.e_v});
      cmp("u1.OVF",   {28'h0, bus1.OVF},   {28'h0, mon_e.e_o});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus0.HOLDOFF = 1'b0;
    bus0.CLR     = 1'b0;
    bus0.START   = 4'h0;
    bus0.STOP    = 4'h0;
    set(32'h0, 32'h0);
    cur_o = 4'h0;

    // ch0: 7-cycle latency
    add(1'b0, 1'b0, 4'h1, 4'h0, 4'h0); idle(6);
    set(32'h00000007, 32'h00000007); add(1'b0, 1'b0, 4'h0, 4'h1, 4'h1); idle(1);
    // ch1: 12 then 5, then CLR
    add(1'b0, 1'b0, 4'h2, 4'h0, 4'h0); idle(11);
    set(32'h00000C07, 32'h00000C07); add(1'b0, 1'b0, 4'h0, 4'h2, 4'h2);
    add(1'b0, 1'b0, 4'h2, 4'h0, 4'h0); idle(4);
    set(32'h00000507, 32'h00000C07); add(1'b0, 1'b0, 4'h0, 4'h2, 4'h2);
    set(32'h0, 32'h0); add(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
    // ch2: START+STOP in IDLE and in RUN, then STOP alone in IDLE
    add(1'b0, 1'b0, 4'h4, 4'h0, 4'h0); idle(2);
    set(32'h00030000, 32'h00030000); add(1'b0, 1'b0, 4'h0, 4'h4, 4'h4);
    set(32'h00000000, 32'h00030000); add(1'b0, 1'b0, 4'h4, 4'h4, 4'h4);
    add(1'b0, 1'b0, 4'h4, 4'h0, 4'h0); idle(3);
    set(32'h00040000, 32'h00040000); add(1'b0, 1'b0, 4'h4, 4'h4, 4'h4);
    add(1'b0, 1'b0, 4'h0, 4'h4, 4'h0);
    // ch3: START at 0 and 4, STOP at 10
    add(1'b0, 1'b0, 4'h8, 4'h0, 4'h0); idle(3);
    add(1'b0, 1'b0, 4'h8, 4'h0, 4'h0); idle(5);
    set2(32'h0A040000, 32'h0A040000, 32'h06040000, 32'h06040000);
    add(1'b0, 1'b0, 4'h0, 4'h8, 4'h8);
    set(32'h0, 32'h0); add(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
    // ch0: CLR mid-run does not disturb the count
    add(1'b0, 1'b0, 4'h1, 4'h0, 4'h0); idle(2);
    add(1'b0, 1'b1, 4'h0, 4'h0, 4'h0); idle(2);
    set(32'h00000006, 32'h00000006); add(1'b0, 1'b0, 4'h0, 4'h1, 4'h1);
    // ch0: HOLDOFF mid-run with a STOP, then immediate new START
    add(1'b0, 1'b0, 4'h1, 4'h0, 4'h0); idle(3);
    add(1'b1, 1'b0, 4'h0, 4'h1, 4'h0);
    add(1'b0, 1'b0, 4'h1, 4'h0, 4'h0); idle(1);
    set(32'h00000002, 32'h00000006); add(1'b0, 1'b0, 4'h0, 4'h1, 4'h1);
    // ch1: saturation and sticky overflow
    add(1'b0, 1'b0, 4'h2, 4'h0, 4'h0); idle(253);
    cur_o = 4'h2; idle(46);
    set(32'h0000FF02, 32'h0000FF06); add(1'b0, 1'b0, 4'h0, 4'h2, 4'h2); idle(1);
    set(32'h0, 32'h0); cur_o = 4'h0; add(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
    // ch2: 1-cycle capture, then leave ch0 running for the reset test
    add(1'b0, 1'b0, 4'h4, 4'h0, 4'h0);
    set(32'h00010000, 32'h00010000); add(1'b0, 1'b0, 4'h0, 4'h4, 4'h4);
    add(1'b0, 1'b0, 4'h1, 4'h0, 4'h0); idle(2);

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    run_table();

    // Asynchronous reset in the middle of a clock period
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;

    vecs.delete();
    set(32'h0, 32'h0);
    cur_o = 4'h0;
    add(1'b0, 1'b0, 4'h0, 4'h1, 4'h0);
    add(1'b0, 1'b0, 4'h1, 4'h0, 4'h0); idle(4);
    set(32'h00000005, 32'h00000005); add(1'b0, 1'b0, 4'h0, 4'h1, 4'h1); idle(1);
    run_table();

    @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trg_timer_mc.md
# trg_timer_mc

Multi-channel, parametrised trigger-latency timer. Each of NCH channels measures the clock-cycle distance from a START strobe to a STOP strobe. It reports the latest result, the running maximum, a one-cycle valid strobe and a sticky overflow flag per channel. It sits in the DMB control trigger path after the L1A/LCT strobe generators and feeds the status/readout registers. It supersedes the single-channel trigger timer by adding channel count, retrigger mode, saturation and statistics.

## Interface
- Width, 8, counter and result width per channel
- NCH, 4, number of independent channels
- RETRIG, 0, 0: START while running is ignored; 1: START while running restarts the measurement
- TMR, 0, 1: triplicate channel state and counters with majority voting
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset of all state and outputs
- HOLDOFF  in  1  synchronous; while high, every channel is forced to IDLE and no capture occurs
- CLR  in  1  synchronous; clears TIME, TMAX and OVF of all channels
- START  in  NCH  per-channel start strobe, sampled on CLK
- STOP  in  NCH  per-channel stop strobe, sampled on CLK
- TIME  out  NCH*Width  last captured latency; channel k occupies bits [k*Width +: Width]
- TMAX  out  NCH*Width  largest latency captured since the last CLR or RST, packed the same way
- VALID  out  NCH  one-cycle pulse, registered with the TIME update
- OVF  out  NCH  sticky; set when a channel's counter saturates

## Operation
- Each channel runs its own two-state FSM: IDLE and RUN.
- IDLE, START=1, STOP=0: cnt<=1, go to RUN.
- IDLE, START=1, STOP=1: TIME<=0, VALID pulses, TMAX is updated, FSM stays in IDLE.
- IDLE, STOP alone: ignored.
- RUN, STOP=1: TIME<=cnt, VALID pulses, TMAX<=max(TMAX,cnt), go to IDLE. STOP takes priority over a simultaneous START in both modes.
- RUN, START=1, STOP=0, RETRIG=1: cnt<=1, stay in RUN, no capture.
- RUN, START=1, STOP=0, RETRIG=0: START is ignored.
- RUN, neither strobe: cnt<=cnt+1, saturating at 2^Width-1. On the cycle cnt reaches all-ones, OVF is set. A later STOP captures all-ones.
- Priority: RST > HOLDOFF > CLR > strobe logic.
- HOLDOFF: forces IDLE and sets cnt to 0. TIME, TMAX and OVF are preserved. VALID stays 0.
- CLR: TIME, TMAX and OVF go to 0 and VALID stays 0 in that cycle. The FSM and cnt are unaffected, so a measurement in progress continues. A STOP in the CLR cycle is dropped.
- Channels are fully independent and have no shared arbitration.

## Timing
- Reset values: TIME=0, TMAX=0, VALID=0, OVF=0, all FSMs in IDLE, cnt=0.
- Latency definition: START sampled at edge t and STOP sampled at edge t+n gives TIME=n, visible after edge t+n. VALID is high for the one cycle after edge t+n.
- Back-to-back operation: STOP at edge t followed by START at edge t+1 is accepted. STOP and START at the same edge in RUN gives a capture; the START is lost.
- RST asserted mid-measurement: the measurement is aborted immediately with no VALID.
- HOLDOFF deassertion: START is accepted at the first edge where HOLDOFF is sampled low.
- Maximum reportable latency is 2^Width-1, which is also the overflow indication.

## Structure
- Shared package trg_timer_pkg holds:
  - state encoding localparams ST_IDLE and ST_RUN
  - CNT_MAX function (2^Width-1)
- One sub-module, trg_timer_ch: a single channel with FSM, counter, TIME/TMAX/OVF/VALID registers, and parameters Width, RETRIG and TMR.
- The top level uses a generate loop over NCH and packs the channel outputs into the buses.
- With TMR=1, trg_timer_ch uses three copies of the state and cnt registers plus a bitwise majority voter.

## Test plan
- Width=8, ch0: START at edge 10, STOP at edge 17 -> TIME[7:0]=7 and VALID[0]=1 for one cycle after edge 17. TMAX=7, OVF=0, other channels untouched.
- Two captures of 12 then 5 on ch1 -> TIME=5, TMAX=12. Then CLR -> TIME=0, TMAX=0.
- RETRIG=0: START at edges 0 and 4, STOP at 10 -> TIME=10. RETRIG=1 with the same stimulus -> TIME=6.
- No STOP for 300 cycles with Width=8 -> OVF set at the 255th cycle after START. A later STOP gives TIME=255 with OVF still 1 until CLR.
- START and STOP together in IDLE -> TIME=0 and VALID=1. START and STOP together in RUN -> capture and return to IDLE.
- HOLDOFF raised mid-run -> no VALID and channel in IDLE. RST pulse mid-run -> all outputs 0 asynchronously. A new START after either is measured correctly.
